serial_adder: RTL and testbench

//  Bit-serial adder for the ALU mini project; inverse-operation companion to the combinational sub unit.

---
 rtl/serial_adder.sv | 118 +++++++++++
 tb/tb_serial_adder.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: WIDTH-bit unsigned operands, WIDTH+1-bit result, one-cycle done strobe.
// Optional subtract mode is compiled in with `define SERIAL_ADDER_SUB_EN.
module serial_adder #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             mode,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   out
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;

  logic             sum_bit_d;
  logic             carry_d;
  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] b_cap_d;
  logic             carry_init_d;
  logic             msb_d;

`ifdef SERIAL_ADDER_SUB_EN
  logic             sub_q;
`endif

  always_comb begin
    sum_bit_d = a_q[0] ^ b_q[0] ^ carry_q;
    carry_d   = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
    sum_d     = {sum_bit_d, sum_q[WIDTH-1:1]};
`ifdef SERIAL_ADDER_SUB_EN
    b_cap_d      = mode ? ~B : B;
    carry_init_d = mode;
    // Subtraction works on WIDTH+1-bit operands: the zero-extended A plus the
    // one-extended ~B flips the top result bit relative to the raw carry out.
    msb_d        = carry_d ^ sub_q;
`else
    b_cap_d      = B;
    carry_init_d = 1'b0;
    msb_d        = carry_d;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      out     <= '0;
`ifdef SERIAL_ADDER_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= A;
            b_q     <= b_cap_d;
            carry_q <= carry_init_d;
            sum_q   <= '0;
            cnt_q   <= '0;
            busy    <= 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
            sub_q   <= mode;
`endif
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          sum_q   <= sum_d;
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          carry_q <= carry_d;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            out     <= {msb_d, sum_d};
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done    <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed + randomized self-checking bench for serial_adder against an arithmetic reference model.
module tb_serial_adder;
  localparam int unsigned W = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         mode;
  logic         busy;
  logic         done;
  logic [W:0]   out;

  int unsigned  n_assert = 0;
  int unsigned  n_fail   = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
`ifdef SERIAL_ADDER_SUB_EN
    .mode  (mode),
`endif
    .busy  (busy),
    .done  (done),
    .out   (out)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Reference: plain modular arithmetic in WIDTH+1 bits.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic m);
    logic [W:0] ea, eb;
    ea = {1'b0, a};
    eb = {1'b0, b};
    return m ? (ea - eb) : (ea + eb);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One operation; with noise, start is re-pulsed (and A/B changed) in SHIFT and DONE.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                        input logic [W:0] exp, input bit noise,
                        input logic [W-1:0] na, input logic [W-1:0] nb);
    A = a; B = b; mode = m; start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < int'(W); i++) begin
      chk("busy_in_shift", busy, 1);
      chk("no_done_in_shift", done, 0);
      if (noise) begin
        A = na; B = nb; start = 1'b1; mode = ~m;
      end
      tick;
    end
    chk("done_strobe", done, 1);
    chk("busy_low_in_done", busy, 0);
    chk("result", out, exp);
    if (noise) begin
      start = 1'b1; A = na; B = nb;
    end
    tick;
    start = 1'b0;
    chk("done_one_cycle", done, 0);
    chk("idle_not_busy", busy, 0);
    chk("result_hold", out, exp);
  endtask

  initial begin
    logic [W-1:0] ra, rb, na, nb;
    logic         rm;
    logic [W-1:0] qa [3];
    logic [W-1:0] qb [3];

    rst = 1'b1; start = 1'b0; A = '0; B = '0; mode = 1'b0;
    tick;
    tick;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_out", out, 0);
    rst = 1'b0;
    tick;

    run_op(3'd5, 3'd3, 1'b0, 4'b1000, 1'b0, '0, '0);
    run_op(3'd7, 3'd7, 1'b0, 4'b1110, 1'b0, '0, '0);
    run_op(3'd0, 3'd0, 1'b0, 4'b0000, 1'b0, '0, '0);
    run_op(3'd1, 3'd2, 1'b0, 4'b0011, 1'b1, 3'd7, 3'd7);

    // Abort mid-operation: reset asserted during the second SHIFT cycle.
    A = 3'd6; B = 3'd5; mode = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    chk("abort_busy_before", busy, 1);
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_out", out, 0);
    for (int i = 0; i < int'(W) + 2; i++) begin
      tick;
      chk("abort_no_done", done, 0);
      chk("abort_no_busy", busy, 0);
    end

`ifdef SERIAL_ADDER_SUB_EN
    run_op(3'd5, 3'd1, 1'b1, 4'b0100, 1'b0, '0, '0);
    run_op(3'd0, 3'd1, 1'b1, 4'b1111, 1'b0, '0, '0);
    run_op(3'd5, 3'd5, 1'b1, 4'b0000, 1'b0, '0, '0);
    run_op(3'd5, 3'd1, 1'b0, 4'b0110, 1'b0, '0, '0);
`endif

    // Start held high: one accept every W+2 cycles.
    for (int k = 0; k < 3; k++) begin
      qa[k] = W'($urandom);
      qb[k] = W'($urandom);
    end
    mode = 1'b0;
    A = qa[0]; B = qb[0]; start = 1'b1;
    tick;
    for (int k = 0; k < 3; k++) begin
      if (k < 2) begin
        A = qa[k+1]; B = qb[k+1];
      end else begin
        start = 1'b0;
      end
      for (int i = 0; i < int'(W); i++) begin
        chk("b2b_busy", busy, 1);
        chk("b2b_no_done", done, 0);
        tick;
      end
      chk("b2b_done", done, 1);
      chk("b2b_result", out, model(qa[k], qb[k], 1'b0));
      tick;
      chk("b2b_idle_busy", busy, 0);
      chk("b2b_idle_done", done, 0);
      if (k < 2) tick;
    end
    start = 1'b0;
    tick;

    for (int n = 0; n < 24; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      na = W'($urandom);
      nb = W'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      rm = 1'($urandom);
`else
      rm = 1'b0;
`endif
      run_op(ra, rb, rm, model(ra, rb, rm), 1'($urandom), na, nb);
      if ($urandom_range(1, 0) == 1) tick;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
